// File: rtl/hyperbus_cfg_seq_pkg.sv
// Package for the hyperbus boot-time configuration sequencer.
//   state_e                 : sequencer FSM states (also exported on dbg_state_o)
//   WSTRB_ALL               : all-ones write strobe, sliced to RegDw/8 by the user
//   DEFAULT_POWER_UP_CYCLES : default HyperRAM power-up wait (tVCS) in clk_i cycles
package hyperbus_cfg_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WAIT  = 3'd1,
        WRITE = 3'd2,
        READ  = 3'd3,
        NEXT  = 3'd4,
        DONE  = 3'd5,
        ERR   = 3'd6
    } state_e;

    // Wide enough for a 1024-bit REG_BUS; users take the low RegDw/8 bits.
    localparam int unsigned     MAX_STRB_W = 128;
    localparam logic [MAX_STRB_W-1:0] WSTRB_ALL = '1;

    localparam int unsigned DEFAULT_POWER_UP_CYCLES = 150;

endpackage

// File: rtl/hyperbus_cfg_seq.sv
// Boot-time configuration sequencer for the hyperbus controller register file.
// After start_i it waits PowerUpCycles cycles (HyperRAM tVCS), then walks an
// external (addr, data) table issuing one REG_BUS write per entry, and reports
// done_o / err_o so the SoC can hold off AXI traffic until configuration ends.
//
// Optional feature: define HYPERBUS_CFG_SEQ_VERIFY_EN to follow every write
// with a readback and compare; a mismatch raises err_o at that entry.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   start_i                start/restart, honoured only in IDLE/DONE/ERR
//   tbl_idx_o              current table index
//   tbl_addr_i/tbl_data_i  table entry at tbl_idx_o (combinational lookup)
//   reg_*                  REG_BUS master side
//   busy_o                 high while WAIT/WRITE/READ/NEXT
//   done_o, err_o          sticky completion / failure flags
//   err_idx_o              failing entry index, valid while err_o
//   dbg_state_o            current FSM state
//
// REG_BUS handshake: reg_valid_o rises in WRITE/READ and, together with
// reg_addr_o, reg_wdata_o, reg_write_o and reg_wstrb_o, is held stable until a
// cycle with reg_valid_o & reg_ready_i; that cycle completes the access and
// only then are reg_error_i / reg_rdata_i looked at. ready may be high in the
// same cycle valid first rises.
module hyperbus_cfg_seq
    import hyperbus_cfg_seq_pkg::*;
#(
    parameter int unsigned RegAw         = 32,
    parameter int unsigned RegDw         = 32,
    parameter int unsigned NumEntries    = 4,
    parameter int unsigned PowerUpCycles = DEFAULT_POWER_UP_CYCLES,
    localparam int unsigned IdxW         = (NumEntries > 1) ? $clog2(NumEntries) : 1
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               start_i,
    output logic [IdxW-1:0]    tbl_idx_o,
    input  logic [RegAw-1:0]   tbl_addr_i,
    input  logic [RegDw-1:0]   tbl_data_i,
    output logic [RegAw-1:0]   reg_addr_o,
    output logic               reg_write_o,
    output logic [RegDw-1:0]   reg_wdata_o,
    output logic [RegDw/8-1:0] reg_wstrb_o,
    output logic               reg_valid_o,
    input  logic [RegDw-1:0]   reg_rdata_i,
    input  logic               reg_error_i,
    input  logic               reg_ready_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               err_o,
    output logic [IdxW-1:0]    err_idx_o,
    output state_e             dbg_state_o
);

    localparam int unsigned CntW = (PowerUpCycles > 1) ? $clog2(PowerUpCycles + 1) : 1;

    state_e            state_q, state_d;
    logic [IdxW-1:0]   idx_q, idx_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              last_entry;
    logic              handshake;

    // NumEntries may be 0, so the "last" test is done in 32-bit arithmetic
    // guarded against the underflow of NumEntries-1.
    assign last_entry = (NumEntries != 0) && (32'(idx_q) == NumEntries - 1);
    assign handshake  = reg_valid_o && reg_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start_i) begin
                    idx_d = '0;
                    if (PowerUpCycles != 0) begin
                        state_d = WAIT;
                        cnt_d   = CntW'(PowerUpCycles);
                    end else if (NumEntries == 0) begin
                        state_d = DONE;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            WAIT: begin
                // Entered with cnt=PowerUpCycles, leaves on cnt==1: exactly
                // PowerUpCycles cycles spent here.
                cnt_d = cnt_q - CntW'(1);
                if (cnt_q == CntW'(1)) begin
                    state_d = (NumEntries == 0) ? DONE : WRITE;
                end
            end
            WRITE: begin
                if (handshake) begin
                    if (reg_error_i) begin
                        state_d = ERR;
                    end else begin
`ifdef HYPERBUS_CFG_SEQ_VERIFY_EN
                        state_d = READ;
`else
                        state_d = last_entry ? DONE : NEXT;
`endif
                    end
                end
            end
`ifdef HYPERBUS_CFG_SEQ_VERIFY_EN
            READ: begin
                if (handshake) begin
                    if (reg_error_i || (reg_rdata_i != tbl_data_i)) begin
                        state_d = ERR;
                    end else begin
                        state_d = last_entry ? DONE : NEXT;
                    end
                end
            end
`endif
            NEXT: begin
                // One bubble so the external table lookup settles on the new index.
                idx_d   = idx_q + IdxW'(1);
                state_d = WRITE;
            end
            default: state_d = IDLE;
        endcase
    end

`ifndef HYPERBUS_CFG_SEQ_VERIFY_EN
    // Readback data has no consumer without the compare logic.
    logic rdata_unused;
    assign rdata_unused = ^reg_rdata_i;
`endif

    assign reg_valid_o = (state_q == WRITE) || (state_q == READ);
`ifdef HYPERBUS_CFG_SEQ_VERIFY_EN
    assign reg_write_o = (state_q == WRITE);
`else
    assign reg_write_o = reg_valid_o;
`endif
    // Bus fields are zero whenever no access is in flight.
    assign reg_addr_o  = reg_valid_o ? tbl_addr_i : '0;
    assign reg_wdata_o = reg_valid_o ? tbl_data_i : '0;
    assign reg_wstrb_o = reg_valid_o ? WSTRB_ALL[RegDw/8-1:0] : '0;

    assign busy_o      = (state_q == WAIT) || (state_q == WRITE) ||
                         (state_q == READ) || (state_q == NEXT);
    assign done_o      = (state_q == DONE);
    assign err_o       = (state_q == ERR);
    assign err_idx_o   = err_o ? idx_q : '0;
    assign tbl_idx_o   = idx_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_hyperbus_cfg_seq.sv
// Directed bench for hyperbus_cfg_seq with PowerUpCycles=4, NumEntries=3.
// Cycle numbering: start_i is high in cycle 0; cycle k is observed 1 time unit
// after the k-th rising edge following that.
module tb_hyperbus_cfg_seq;
    import hyperbus_cfg_seq_pkg::*;

    localparam int P    = 4;
    localparam int N    = 3;
    localparam int IdxW = 2;
`ifdef HYPERBUS_CFG_SEQ_VERIFY_EN
    localparam int PER  = 3;   // write, read, next
`else
    localparam int PER  = 2;   // write, next
`endif
    localparam int FIRST_C = P + 1;                  // first WRITE cycle
    localparam int DONE_C  = FIRST_C + PER * N - 1;  // first DONE cycle

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic              start_i;
    logic [IdxW-1:0]   tbl_idx_o;
    logic [31:0]       tbl_addr_i, tbl_data_i;
    logic [31:0]       reg_addr_o, reg_wdata_o, reg_rdata_i;
    logic              reg_write_o, reg_valid_o, reg_error_i, reg_ready_i;
    logic [3:0]        reg_wstrb_o;
    logic              busy_o, done_o, err_o;
    logic [IdxW-1:0]   err_idx_o;
    state_e            dbg_state_o;

    logic [31:0] t_addr [N] = '{32'h0000_0010, 32'h0000_0014, 32'h0000_0018};
    logic [31:0] t_data [N] = '{32'hA5A5_0000, 32'h5A5A_1111, 32'h1234_5678};

    int err_at = -1;   // entry whose write returns reg_error_i
    int bad_rd = -1;   // entry whose readback returns data^1
    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    always #5 clk_i = ~clk_i;

    assign tbl_addr_i  = t_addr[tbl_idx_o];
    assign tbl_data_i  = t_data[tbl_idx_o];
    assign reg_error_i = reg_valid_o && reg_write_o && (int'(tbl_idx_o) == err_at);
    assign reg_rdata_i = (int'(tbl_idx_o) == bad_rd) ? (tbl_data_i ^ 32'h1) : tbl_data_i;

    hyperbus_cfg_seq #(
        .RegAw(32), .RegDw(32), .NumEntries(N), .PowerUpCycles(P)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
        .tbl_idx_o(tbl_idx_o), .tbl_addr_i(tbl_addr_i), .tbl_data_i(tbl_data_i),
        .reg_addr_o(reg_addr_o), .reg_write_o(reg_write_o), .reg_wdata_o(reg_wdata_o),
        .reg_wstrb_o(reg_wstrb_o), .reg_valid_o(reg_valid_o), .reg_rdata_i(reg_rdata_i),
        .reg_error_i(reg_error_i), .reg_ready_i(reg_ready_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o), .err_idx_o(err_idx_o),
        .dbg_state_o(dbg_state_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
        cyc++;
    endtask

    // Raise start_i for cycle 0 and land in cycle 1.
    task automatic kick();
        start_i = 1'b1;
        cyc     = 0;
        step();
        start_i = 1'b0;
    endtask

    task automatic go(input int target);
        while (cyc < target) step();
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done_o && !err_o && n < budget) begin
            step();
            n++;
        end
        check(tag, {31'd0, done_o}, 32'd1);
    endtask

    initial begin
        rst_ni      = 1'b0;
        start_i     = 1'b0;
        reg_ready_i = 1'b1;

        // ---------------- reset state ----------------
        repeat (2) @(negedge clk_i);
        check("rst_valid", {31'd0, reg_valid_o}, 32'd0);
        check("rst_busy",  {31'd0, busy_o}, 32'd0);
        check("rst_done",  {31'd0, done_o}, 32'd0);
        check("rst_err",   {31'd0, err_o}, 32'd0);
        check("rst_idx",   {30'd0, tbl_idx_o}, 32'd0);
        check("rst_addr",  reg_addr_o, 32'd0);
        check("rst_wstrb", {28'd0, reg_wstrb_o}, 32'd0);
        check("rst_state", {29'd0, dbg_state_o}, {29'd0, IDLE});
        rst_ni = 1'b1;
        repeat (3) step();
        check("idle_no_access", {31'd0, reg_valid_o | busy_o}, 32'd0);

        // ---------------- T1: nominal sequence, ready=1 ----------------
        kick();
        for (int c = 1; c <= DONE_C; c++) begin
            int  e, off;
            logic ev;
            if (c > 1) step();
            e   = (c >= FIRST_C) ? (c - FIRST_C) / PER : 0;
            off = (c >= FIRST_C) ? (c - FIRST_C) % PER : 0;
            ev  = (c >= FIRST_C) && (c < DONE_C) && (off < PER - 1);
            check($sformatf("t1_valid_c%0d", c), {31'd0, reg_valid_o}, {31'd0, ev});
            check($sformatf("t1_busy_c%0d", c), {31'd0, busy_o}, {31'd0, c < DONE_C});
            check($sformatf("t1_done_c%0d", c), {31'd0, done_o}, {31'd0, c == DONE_C});
            if (ev) begin
                check($sformatf("t1_addr_c%0d", c), reg_addr_o, t_addr[e]);
                check($sformatf("t1_write_c%0d", c), {31'd0, reg_write_o}, {31'd0, off == 0});
                check($sformatf("t1_wstrb_c%0d", c), {28'd0, reg_wstrb_o}, 32'hF);
                if (off == 0) check($sformatf("t1_wdata_c%0d", c), reg_wdata_o, t_data[e]);
            end
        end
        step();
        check("t1_done_sticky", {31'd0, done_o}, 32'd1);

        // ---------------- T2: ready low 3 cycles on entry 0 ----------------
        reg_ready_i = 1'b0;
        kick();
        check("t2_done_cleared", {31'd0, done_o}, 32'd0);
        go(FIRST_C);
        for (int c = FIRST_C; c < FIRST_C + 4; c++) begin
            if (c > FIRST_C) step();
            if (c == FIRST_C + 3) reg_ready_i = 1'b1;
            check($sformatf("t2_valid_c%0d", c), {31'd0, reg_valid_o}, 32'd1);
            check($sformatf("t2_addr_c%0d", c), reg_addr_o, t_addr[0]);
            check($sformatf("t2_wdata_c%0d", c), reg_wdata_o, t_data[0]);
            check($sformatf("t2_idx_c%0d", c), {30'd0, tbl_idx_o}, 32'd0);
        end
        begin
            int n = 0;
            while (tbl_idx_o != 2'd1 && n < 10) begin
                step();
                n++;
            end
        end
        check("t2_idx1_cycle", cyc, FIRST_C + 3 + PER);
        check("t2_idx1_valid", {31'd0, reg_valid_o}, 32'd1);
        check("t2_idx1_addr",  reg_addr_o, t_addr[1]);
        wait_done("t2_done", 20);

        // ---------------- T3: write error on entry 1 ----------------
        err_at = 1;
        kick();
        check("t3_done_cleared", {31'd0, done_o}, 32'd0);
        go(FIRST_C + PER);
        check("t3_e1_valid", {31'd0, reg_valid_o}, 32'd1);
        check("t3_e1_addr",  reg_addr_o, t_addr[1]);
        step();
        check("t3_err",     {31'd0, err_o}, 32'd1);
        check("t3_err_idx", {30'd0, err_idx_o}, 32'd1);
        check("t3_done",    {31'd0, done_o}, 32'd0);
        check("t3_busy",    {31'd0, busy_o}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t3_no_valid_%0d", k), {31'd0, reg_valid_o}, 32'd0);
            step();
        end
        check("t3_err_sticky", {31'd0, err_o}, 32'd1);
        err_at = -1;

`ifdef HYPERBUS_CFG_SEQ_VERIFY_EN
        // ---------------- T4: readback mismatch on entry 2 ----------------
        bad_rd = 2;
        kick();
        check("t4_err_cleared", {31'd0, err_o}, 32'd0);
        go(FIRST_C + 2 * PER);
        check("t4_wr_valid", {31'd0, reg_valid_o & reg_write_o}, 32'd1);
        check("t4_wr_addr",  reg_addr_o, t_addr[2]);
        step();
        check("t4_rd_valid", {31'd0, reg_valid_o}, 32'd1);
        check("t4_rd_write", {31'd0, reg_write_o}, 32'd0);
        check("t4_rd_addr",  reg_addr_o, t_addr[2]);
        step();
        check("t4_err",     {31'd0, err_o}, 32'd1);
        check("t4_err_idx", {30'd0, err_idx_o}, 32'd2);
        check("t4_done",    {31'd0, done_o}, 32'd0);
        bad_rd = -1;
`endif

        // ---------------- T5: async reset in WAIT and mid-access ----------------
        kick();
        go(2);
        check("t5_in_wait", {31'd0, busy_o}, 32'd1);
        rst_ni = 1'b0;
        #1;
        check("t5a_busy",  {31'd0, busy_o}, 32'd0);
        check("t5a_err",   {31'd0, err_o}, 32'd0);
        check("t5a_state", {29'd0, dbg_state_o}, {29'd0, IDLE});
        @(negedge clk_i);
        rst_ni = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("t5a_quiet_%0d", k), {31'd0, reg_valid_o | busy_o}, 32'd0);
        end
        reg_ready_i = 1'b0;
        kick();
        go(FIRST_C + 1);
        check("t5b_valid_pre", {31'd0, reg_valid_o}, 32'd1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("t5b_valid", {31'd0, reg_valid_o}, 32'd0);
        check("t5b_write", {31'd0, reg_write_o}, 32'd0);
        check("t5b_addr",  reg_addr_o, 32'd0);
        check("t5b_wstrb", {28'd0, reg_wstrb_o}, 32'd0);
        check("t5b_busy",  {31'd0, busy_o}, 32'd0);
        @(negedge clk_i);
        rst_ni      = 1'b1;
        reg_ready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check($sformatf("t5b_quiet_%0d", k), {31'd0, reg_valid_o | busy_o}, 32'd0);
        end

        // ---------------- T6: start ignored while busy, rerun after DONE ----------------
        kick();
        go(3);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        go(FIRST_C);
        check("t6_valid_c5", {31'd0, reg_valid_o}, 32'd1);
        check("t6_addr_c5",  reg_addr_o, t_addr[0]);
        go(FIRST_C + 2);
        start_i = 1'b1;
        step();
        start_i = 1'b0;
        go(DONE_C);
        check("t6_done", {31'd0, done_o}, 32'd1);
        kick();
        check("t6_rerun_done", {31'd0, done_o}, 32'd0);
        check("t6_rerun_busy", {31'd0, busy_o}, 32'd1);
        check("t6_rerun_idx",  {30'd0, tbl_idx_o}, 32'd0);
        go(FIRST_C);
        check("t6_rerun_valid", {31'd0, reg_valid_o}, 32'd1);
        check("t6_rerun_addr",  reg_addr_o, t_addr[0]);
        wait_done("t6_rerun_complete", 20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
